// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: event lines and mask write from the system side,
// request/acknowledge/end-of-interrupt handshake with the control unit.
//
// Handshake: int_req is held high with a stable int_vec until the control
// unit pulses int_ack for one cycle; the controller drops int_req on that
// edge. eoi is a one-cycle strobe that closes the in-service interrupt.
// int_ack is honoured only while int_req is high, and eoi only while an
// interrupt is in service.
interface int_ctrl_if #(
  parameter int NIRQ  = 4,
  parameter int VEC_W = 10
);
  logic [NIRQ-1:0]  irq_in;
  logic             mask_we;
  logic [NIRQ-1:0]  mask_data;
  logic             int_ack;
  logic             eoi;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [NIRQ-1:0]  pending;
  logic [NIRQ-1:0]  in_service;

  // System/control-unit side
  modport master (
    output irq_in, mask_we, mask_data, int_ack, eoi,
    input  int_req, int_vec, pending, in_service
  );

  // Controller side
  modport slave (
    input  irq_in, mask_we, mask_data, int_ack, eoi,
    output int_req, int_vec, pending, in_service
  );
endinterface

// File: rtl/int_ctrl.sv
// Prioritised, non-nested interrupt controller. Rising edges on irq_in are
// latched into pending, filtered by a CPU-written mask, and the lowest-index
// eligible line is presented to the control unit as int_req + int_vec.
module int_ctrl #(
  parameter int               NIRQ     = 4,
  parameter int               VEC_W    = 10,
  parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic       clk,
  input  logic       reset,
  int_ctrl_if.slave  bus,
  output logic [1:0] state_dbg
);

  localparam int ID_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [NIRQ-1:0]  irq_q;
  logic [NIRQ-1:0]  rise;
  logic [NIRQ-1:0]  pending_r;
  logic [NIRQ-1:0]  mask_r;
  logic [NIRQ-1:0]  eligible;
  logic [NIRQ-1:0]  in_service_r;
  logic [NIRQ-1:0]  sel_onehot;
  logic [NIRQ-1:0]  clr;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  pick;
  logic             ack_fire;
  logic             int_req_r;
  logic [VEC_W-1:0] int_vec_r;

  assign rise       = bus.irq_in & ~irq_q;
  assign eligible   = pending_r & ~mask_r;
  assign sel_onehot = {{(NIRQ-1){1'b0}}, 1'b1} << sel_id;
  assign ack_fire   = (state == REQ) && bus.int_ack;
  assign clr        = ack_fire ? sel_onehot : '0;

  assign bus.int_req    = int_req_r;
  assign bus.int_vec    = int_vec_r;
  assign bus.pending    = pending_r;
  assign bus.in_service = in_service_r;
  assign state_dbg      = state;

  // Fixed priority: scan from the top so the lowest eligible index wins.
  always_comb begin
    pick = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) pick = ID_W'(i);
    end
  end

  // Edge-detect history; loads through reset so lines held high produce no event.
  always_ff @(posedge clk) begin
    irq_q <= bus.irq_in;
  end

  // Pending events: a rise in the ack cycle re-sets the bit being cleared.
  always_ff @(posedge clk) begin
    if (reset) pending_r <= '0;
    else       pending_r <= (pending_r & ~clr) | rise;
  end

  // Mask register, all lines masked out of reset.
  always_ff @(posedge clk) begin
    if (reset)            mask_r <= '1;
    else if (bus.mask_we) mask_r <= bus.mask_data;
  end

  // Request/service FSM with registered request, vector and in-service outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sel_id       <= '0;
      int_req_r    <= 1'b0;
      int_vec_r    <= VEC_BASE;
      in_service_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            sel_id    <= pick;
            int_vec_r <= VEC_BASE + VEC_W'(pick);
            int_req_r <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // Ack takes precedence over a simultaneous mask-out of the same line.
          if (bus.int_ack) begin
            int_req_r    <= 1'b0;
            in_service_r <= sel_onehot;
            state        <= SERVICE;
          end else if (bus.mask_we && bus.mask_data[sel_id]) begin
            int_req_r <= 1'b0;
            state     <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            in_service_r <= '0;
            state        <= IDLE;
          end
        end
        default: begin
          int_req_r <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: each task drives one scenario and checks
// pending, in_service, int_req, int_vec and FSM state against hand values.
module tb_int_ctrl;

  localparam int NIRQ  = 4;
  localparam int VEC_W = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  int_ctrl_if #(.NIRQ(NIRQ), .VEC_W(VEC_W)) bus ();

  int_ctrl #(.NIRQ(NIRQ), .VEC_W(VEC_W), .VEC_BASE(10'h3F0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we   = 1'b1;
    bus.mask_data = m;
    step();
    bus.mask_we   = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    step();
    bus.eoi = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.int_req); end
    checks++; if (bus.int_vec !== 10'h3F0) begin errors++; $display("FAIL rst_vec got %h exp 3f0", bus.int_vec); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got %b exp 0000", bus.pending); end
    checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL rst_insvc got %b exp 0000", bus.in_service); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_basic();
    write_mask(4'b0000);
    bus.irq_in = 4'b0100;
    step(); // edge k
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL basic_pending got %b exp 0100", bus.pending); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL basic_req_k got %b exp 0", bus.int_req); end
    bus.irq_in = 4'b0000;
    step(); // edge k+1
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", bus.int_req); end
    checks++; if (bus.int_vec !== 10'h3F2) begin errors++; $display("FAIL basic_vec got %h exp 3f2", bus.int_vec); end
    pulse_ack();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ack_req got %b exp 0", bus.int_req); end
    checks++; if (bus.in_service !== 4'b0100) begin errors++; $display("FAIL ack_insvc got %b exp 0100", bus.in_service); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL ack_pending got %b exp 0000", bus.pending); end
    step();
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL svc_state got %0d exp 2", state_dbg); end
    pulse_eoi();
    checks++; if (bus.in_service !== 4'b0000) begin errors++; $display("FAIL eoi_insvc got %b exp 0000", bus.in_service); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL eoi_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_priority();
    bus.irq_in = 4'b1010;
    step();
    checks++; if (bus.pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got %b exp 1010", bus.pending); end
    bus.irq_in = 4'b0000;
    step();
    checks++; if (bus.int_vec !== 10'h3F1 || bus.int_req !== 1'b1) begin errors++; $display("FAIL prio_first got req %b vec %h exp 1 3f1", bus.int_req, bus.int_vec); end
    pulse_ack();
    checks++; if (bus.pending !== 4'b1000 || bus.in_service !== 4'b0010) begin errors++; $display("FAIL prio_ack got pend %b insvc %b exp 1000 0010", bus.pending, bus.in_service); end
    pulse_eoi(); // edge m
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL prio_m got %b exp 0", bus.int_req); end
    step(); // edge m+1
    checks++; if (bus.int_vec !== 10'h3F3 || bus.int_req !== 1'b1) begin errors++; $display("FAIL prio_second got req %b vec %h exp 1 3f3", bus.int_req, bus.int_vec); end
    pulse_ack();
    pulse_eoi();
    checks++; if (bus.pending !== 4'b0000 || state_dbg !== 2'd0) begin errors++; $display("FAIL prio_clean got pend %b state %0d exp 0000 0", bus.pending, state_dbg); end
  endtask

  task automatic test_non_nested();
    bus.irq_in = 4'b0001;
    step();
    bus.irq_in = 4'b0000;
    step();
    checks++; if (bus.int_vec !== 10'h3F0 || bus.int_req !== 1'b1) begin errors++; $display("FAIL nn_req got req %b vec %h exp 1 3f0", bus.int_req, bus.int_vec); end
    pulse_ack();
    bus.irq_in = 4'b0001;
    step();
    checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL nn_pending got %b exp 0001", bus.pending); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL nn_req_svc got %b exp 0", bus.int_req); end
    bus.irq_in = 4'b0000;
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL nn_req_svc2 got %b exp 0", bus.int_req); end
    pulse_eoi();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL nn_req_m got %b exp 0", bus.int_req); end
    step();
    checks++; if (bus.int_vec !== 10'h3F0 || bus.int_req !== 1'b1) begin errors++; $display("FAIL nn_rereq got req %b vec %h exp 1 3f0", bus.int_req, bus.int_vec); end
    pulse_ack();
    pulse_eoi();
  endtask

  task automatic test_default_mask();
    do_reset();
    bus.irq_in = 4'b0010;
    step();
    checks++; if (bus.pending !== 4'b0010) begin errors++; $display("FAIL dm_pending got %b exp 0010", bus.pending); end
    bus.irq_in = 4'b0000;
    step();
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL dm_masked got %b exp 0", bus.int_req); end
    write_mask(4'b0000); // edge w
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL dm_w got %b exp 0", bus.int_req); end
    step(); // edge w+1
    checks++; if (bus.int_vec !== 10'h3F1 || bus.int_req !== 1'b1) begin errors++; $display("FAIL dm_unmask got req %b vec %h exp 1 3f1", bus.int_req, bus.int_vec); end
    pulse_ack();
    pulse_eoi();
  endtask

  task automatic test_withdraw();
    bus.irq_in = 4'b0100;
    step();
    bus.irq_in = 4'b0000;
    step();
    checks++; if (bus.int_vec !== 10'h3F2 || bus.int_req !== 1'b1) begin errors++; $display("FAIL wd_req got req %b vec %h exp 1 3f2", bus.int_req, bus.int_vec); end
    write_mask(4'b0100);
    checks++; if (bus.int_req !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL wd_drop got req %b state %0d exp 0 0", bus.int_req, state_dbg); end
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL wd_pending got %b exp 0100", bus.pending); end
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL wd_stay got %b exp 0", bus.int_req); end
    // Strobes outside their states are ignored.
    pulse_ack();
    checks++; if (bus.pending !== 4'b0100 || bus.in_service !== 4'b0000) begin errors++; $display("FAIL stray_ack got pend %b insvc %b exp 0100 0000", bus.pending, bus.in_service); end
    pulse_eoi();
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL stray_eoi got %0d exp 0", state_dbg); end
  endtask

  task automatic test_ack_beats_mask();
    write_mask(4'b0000);
    step();
    checks++; if (bus.int_vec !== 10'h3F2 || bus.int_req !== 1'b1) begin errors++; $display("FAIL am_req got req %b vec %h exp 1 3f2", bus.int_req, bus.int_vec); end
    bus.int_ack   = 1'b1;
    bus.mask_we   = 1'b1;
    bus.mask_data = 4'b0100;
    step();
    bus.int_ack   = 1'b0;
    bus.mask_we   = 1'b0;
    checks++; if (bus.in_service !== 4'b0100 || state_dbg !== 2'd2) begin errors++; $display("FAIL am_ack got insvc %b state %0d exp 0100 2", bus.in_service, state_dbg); end
    pulse_eoi();
    write_mask(4'b0000);
  endtask

  task automatic test_reset_held();
    bus.irq_in = 4'b0001;
    step();
    bus.irq_in = 4'b0000;
    step();
    pulse_ack();
    bus.irq_in = 4'b0010;
    step();
    checks++; if (bus.pending !== 4'b0010 || bus.in_service !== 4'b0001) begin errors++; $display("FAIL rh_pre got pend %b insvc %b exp 0010 0001", bus.pending, bus.in_service); end
    bus.irq_in = 4'b0001;
    reset      = 1'b1;
    step();
    checks++; if (bus.pending !== 4'b0000 || bus.in_service !== 4'b0000 || bus.int_req !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL rh_mid got pend %b insvc %b req %b state %0d exp 0000 0000 0 0", bus.pending, bus.in_service, bus.int_req, state_dbg); end
    step();
    reset = 1'b0;
    write_mask(4'b0000);
    step();
    checks++; if (bus.pending !== 4'b0000 || bus.int_req !== 1'b0) begin errors++; $display("FAIL rh_held got pend %b req %b exp 0000 0", bus.pending, bus.int_req); end
    bus.irq_in = 4'b0000;
  endtask

  initial begin
    reset         = 1'b1;
    bus.irq_in    = '0;
    bus.mask_we   = 1'b0;
    bus.mask_data = '0;
    bus.int_ack   = 1'b0;
    bus.eoi       = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_non_nested();
    test_default_mask();
    test_withdraw();
    test_ack_beats_mask();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

- Prioritised interrupt controller sitting beside the single-cycle CPU, between external event lines and the control unit.
- Latches rising edges on up to NIRQ request lines and applies a CPU-written mask.
- Presents the highest-priority unmasked event to the control unit as a request plus jump vector.
- Tracks the in-service interrupt through a request/acknowledge/end-of-interrupt handshake; non-nested: one interrupt in service at a time.

## Interface
- NIRQ, 4, number of interrupt lines (2..8).
- VEC_W, 10, width of the vector, equal to the PC width.
- VEC_BASE, 10'h3F0, address of vector 0; vector i = VEC_BASE + i.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NIRQ  external request lines, edge-triggered, synchronous to clk.
- mask_we  in  1  write strobe for the mask register.
- mask_data  in  NIRQ  new mask; bit=1 masks that line.
- int_ack  in  1  one-cycle strobe from control unit: vector taken (PC pushed, vector loaded).
- eoi  in  1  one-cycle strobe from control unit: return-from-interrupt executed.
- int_req  out  1  interrupt request to control unit.
- int_vec  out  VEC_W  jump target; valid while int_req=1.
- pending  out  NIRQ  latched, not-yet-acknowledged events.
- in_service  out  NIRQ  one-hot id being serviced, 0 when none.

## Operation
- Edge detect: irq_q <= irq_in every cycle. rise = irq_in & ~irq_q.
  - During reset irq_q still loads irq_in, so lines held high through reset produce no event.
- pending[i] is set on rise[i] and cleared when id i is acknowledged.
  - A rise on the acknowledged id in the ack cycle wins: the bit stays set.
- eligible = pending & ~mask. Priority is fixed: lowest index highest.
- Mask register: loaded from mask_data on mask_we; reset value all ones (all masked).
- FSM, registered state:
  - IDLE: if eligible != 0, latch sel_id = highest-priority eligible id, go to REQ. Otherwise stay.
  - REQ: int_req=1, int_vec = VEC_BASE + sel_id (zero-extended add, modulo 2^VEC_W). sel_id is frozen; a higher-priority event arriving now is not swapped in.
    - int_ack: clear pending[sel_id], set in_service = onehot(sel_id), go to SERVICE.
    - No ack, and mask_we writes a 1 to bit sel_id: withdraw, go to IDLE. pending bit kept.
    - int_ack and such a mask write in the same cycle: ack wins.
  - SERVICE: int_req=0. New events accumulate in pending but are not requested.
    - eoi: clear in_service, go to IDLE.
- Ignored strobes: int_ack outside REQ; eoi outside SERVICE. Both have no effect.
- pending, mask and irq_q update in every state.

## Timing
- Reset values: state=IDLE, int_req=0, int_vec=VEC_BASE, pending=0, in_service=0, mask=all ones, sel_id=0.
- int_req and int_vec are registered, from state and sel_id; no combinational path from any input.
- Event latency, with the line unmasked:
  - irq_in first sampled high at edge k: pending visible after k.
  - REQ and int_req=1 after edge k+1.
- Acknowledge: int_ack sampled at edge a: int_req=0 and in_service valid after a.
- End of interrupt: eoi at edge m: IDLE after m. If eligible is non-zero, int_req=1 again after m+1.
- Mask write at edge w: affects the IDLE decision from edge w+1.
- Reset mid-REQ or mid-SERVICE returns to the reset state on the next edge; all pending events are discarded.

## Test plan
- Reset, then mask_data=4'b0000 write; pulse irq_in[2] high at edge k -> pending=4'b0100 after k; int_req=1, int_vec=10'h3F2 after k+1.
- In REQ: int_ack one cycle -> int_req=0, in_service=4'b0100, pending=0. eoi -> in_service=0, IDLE.
- irq_in[3] and irq_in[1] rise in the same cycle, all unmasked -> vector 10'h3F1 first. After ack+eoi, int_req reasserts with 10'h3F3 two edges after eoi.
- In SERVICE of id 0: irq_in[0] rises again -> pending[0]=1, int_req stays 0 until after eoi. Then int_req=1 with 10'h3F0.
- Default mask after reset: irq_in[1] rises -> pending=4'b0010, int_req stays 0. Unmask -> int_req=1 two edges after the mask write.
- In REQ for id 2: mask_we sets bit 2 without ack -> int_req=0 next cycle, pending[2] still 1. irq_in[0] held high across reset -> no event after reset.
